// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the fetch/data memory port arbiter.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        WAIT   = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_D  = 1'b1
    } gnt_t;

    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    // Wide enough for RD_LAT-1 with RD_LAT up to 7.
    localparam int LAT_CNT_W = 3;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Counts consecutive data grants taken while a fetch is waiting; forces a
// fetch grant once the count saturates.
module mem_arb_starve_ctr
    import mem_port_arbiter_pkg::*;
#(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic nreset,
    input  logic clk_en,
    input  logic if_req,
    input  logic gnt_if,
    input  logic gnt_d,
    output logic force_if
);

    localparam int CNT_W = $clog2(STARVE_MAX + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_MAX);

    logic [CNT_W-1:0] cnt;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            cnt <= '0;
        end else if (clk_en) begin
            if (gnt_if) begin
                cnt <= '0;
            end else if (gnt_d) begin
                // A data grant only counts against fetch if fetch was waiting.
                if (!if_req) begin
                    cnt <= '0;
                end else if (cnt != CNT_MAX) begin
                    cnt <= cnt + 1'b1;
                end
            end
        end
    end

    assign force_if = if_req && (cnt == CNT_MAX);

endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises CPU fetch and data accesses onto one single-ported memory,
// sequencing strobe and read latency and returning one-cycle valid pulses.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 32,
    parameter int DATA_W     = 32,
    parameter int RD_LAT     = 1,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk,
    input  logic              nreset,
    input  logic              clk_en,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_valid,
    input  logic              d_rd,
    input  logic              d_wr,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic [DATA_W-1:0] d_rdata,
    output logic              d_valid,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_rd,
    output logic              mem_wr,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy,
    output logic              err
);

    localparam logic [LAT_CNT_W-1:0] LAT_LOAD = LAT_CNT_W'(RD_LAT - 1);

    state_t               state, state_nx;
    gnt_t                 gnt, gnt_nx;
    op_t                  op, op_nx;
    logic [LAT_CNT_W-1:0] lat_cnt, lat_cnt_nx;

    logic [DATA_W-1:0] if_rdata_nx, d_rdata_nx, mem_wdata_nx;
    logic [ADDR_W-1:0] mem_addr_nx;
    logic              if_valid_nx, d_valid_nx, mem_rd_nx, mem_wr_nx;
    logic              busy_nx, err_nx;

    logic d_req, pick_if, force_if;
    logic gnt_if_evt, gnt_d_evt;

    assign d_req   = d_rd | d_wr;
    assign pick_if = if_req & (~d_req | force_if);

    mem_arb_starve_ctr #(
        .STARVE_MAX (STARVE_MAX)
    ) u_starve_ctr (
        .clk      (clk),
        .nreset   (nreset),
        .clk_en   (clk_en),
        .if_req   (if_req),
        .gnt_if   (gnt_if_evt),
        .gnt_d    (gnt_d_evt),
        .force_if (force_if)
    );

    always_comb begin
        state_nx     = state;
        gnt_nx       = gnt;
        op_nx        = op;
        lat_cnt_nx   = lat_cnt;
        if_rdata_nx  = if_rdata;
        d_rdata_nx   = d_rdata;
        mem_addr_nx  = mem_addr;
        mem_wdata_nx = mem_wdata;
        err_nx       = err;
        if_valid_nx  = 1'b0;
        d_valid_nx   = 1'b0;
        mem_rd_nx    = 1'b0;
        mem_wr_nx    = 1'b0;
        gnt_if_evt   = 1'b0;
        gnt_d_evt    = 1'b0;

        unique case (state)
            IDLE: begin
                if (d_rd && d_wr) begin
                    err_nx = 1'b1;
                end
                if (pick_if) begin
                    gnt_nx      = GNT_IF;
                    op_nx       = OP_RD;
                    mem_addr_nx = if_addr;
                    mem_rd_nx   = 1'b1;
                    gnt_if_evt  = 1'b1;
                    state_nx    = ACCESS;
                end else if (d_req) begin
                    // Conflicting rd+wr resolves to a write.
                    gnt_nx       = GNT_D;
                    op_nx        = d_wr ? OP_WR : OP_RD;
                    mem_addr_nx  = d_addr;
                    mem_wdata_nx = d_wdata;
                    mem_rd_nx    = ~d_wr;
                    mem_wr_nx    = d_wr;
                    gnt_d_evt    = 1'b1;
                    state_nx     = ACCESS;
                end
            end
            ACCESS: begin
                if (op == OP_WR) begin
                    d_valid_nx = (gnt == GNT_D);
                    if_valid_nx = (gnt == GNT_IF);
                    state_nx   = DONE;
                end else begin
                    lat_cnt_nx = LAT_LOAD;
                    state_nx   = WAIT;
                end
            end
            WAIT: begin
                if (lat_cnt == '0) begin
                    if (gnt == GNT_IF) begin
                        if_rdata_nx = mem_rdata;
                        if_valid_nx = 1'b1;
                    end else begin
                        d_rdata_nx = mem_rdata;
                        d_valid_nx = 1'b1;
                    end
                    state_nx = DONE;
                end else begin
                    lat_cnt_nx = lat_cnt - 1'b1;
                end
            end
            DONE: begin
                // Requests are not sampled here; requesters drop them on valid.
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase

        busy_nx = (state_nx != IDLE);
    end

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state     <= IDLE;
            gnt       <= GNT_IF;
            op        <= OP_RD;
            lat_cnt   <= '0;
            if_rdata  <= '0;
            if_valid  <= 1'b0;
            d_rdata   <= '0;
            d_valid   <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_rd    <= 1'b0;
            mem_wr    <= 1'b0;
            busy      <= 1'b0;
            err       <= 1'b0;
        end else if (clk_en) begin
            state     <= state_nx;
            gnt       <= gnt_nx;
            op        <= op_nx;
            lat_cnt   <= lat_cnt_nx;
            if_rdata  <= if_rdata_nx;
            if_valid  <= if_valid_nx;
            d_rdata   <= d_rdata_nx;
            d_valid   <= d_valid_nx;
            mem_addr  <= mem_addr_nx;
            mem_wdata <= mem_wdata_nx;
            mem_rd    <= mem_rd_nx;
            mem_wr    <= mem_wr_nx;
            busy      <= busy_nx;
            err       <= err_nx;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed and randomized bench for mem_port_arbiter with a latency-accurate
// memory model and a transaction-level reference of memory contents.
module tb_mem_port_arbiter;

    localparam int RD_LAT     = 3;
    localparam int STARVE_MAX = 4;
    localparam int GATE_LEN   = 5;

    logic        clk;
    logic        nreset;
    logic        clk_en;
    logic        if_req;
    logic [31:0] if_addr;
    logic [31:0] if_rdata;
    logic        if_valid;
    logic        d_rd;
    logic        d_wr;
    logic [31:0] d_addr;
    logic [31:0] d_wdata;
    logic [31:0] d_rdata;
    logic        d_valid;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_rd;
    logic        mem_wr;
    logic [31:0] mem_rdata;
    logic        busy;
    logic        err;

    int errors = 0;
    int checks = 0;

    mem_port_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .RD_LAT     (RD_LAT),
        .STARVE_MAX (STARVE_MAX)
    ) dut (
        .clk       (clk),
        .nreset    (nreset),
        .clk_en    (clk_en),
        .if_req    (if_req),
        .if_addr   (if_addr),
        .if_rdata  (if_rdata),
        .if_valid  (if_valid),
        .d_rd      (d_rd),
        .d_wr      (d_wr),
        .d_addr    (d_addr),
        .d_wdata   (d_wdata),
        .d_rdata   (d_rdata),
        .d_valid   (d_valid),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_rd    (mem_rd),
        .mem_wr    (mem_wr),
        .mem_rdata (mem_rdata),
        .busy      (busy),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Power-on memory image: 0x100 holds a known word, everything else a hash.
    function automatic logic [31:0] mem_init(input logic [31:0] a);
        if (a == 32'h100) return 32'hDEAD_BEEF;
        return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
    endfunction

    // Memory macro: same clock enable, RD_LAT enabled cycles of read latency.
    logic [31:0] mem_arr [0:4095];
    bit          mem_vld [0:4095];
    logic [31:0] pipe    [0:RD_LAT-1];

    function automatic logic [31:0] mem_peek(input logic [31:0] a);
        return mem_vld[a[13:2]] ? mem_arr[a[13:2]] : mem_init(a);
    endfunction

    always @(posedge clk) begin
        if (clk_en) begin
            if (mem_wr) begin
                mem_arr[mem_addr[13:2]] <= mem_wdata;
                mem_vld[mem_addr[13:2]] <= 1'b1;
            end
            pipe[0] <= mem_rd ? mem_peek(mem_addr) : $urandom();
            for (int i = 1; i < RD_LAT; i++) pipe[i] <= pipe[i-1];
        end
    end
    assign mem_rdata = pipe[RD_LAT-1];

    // Reference view of memory contents, updated only by the stimulus.
    logic [31:0] ref_arr [0:4095];
    bit          ref_vld [0:4095];

    function automatic logic [31:0] ref_get(input logic [31:0] a);
        return ref_vld[a[13:2]] ? ref_arr[a[13:2]] : mem_init(a);
    endfunction

    task automatic ref_put(input logic [31:0] a, input logic [31:0] d);
        ref_arr[a[13:2]] = d;
        ref_vld[a[13:2]] = 1'b1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // One isolated transaction: drive request, wait for completion, report what
    // the memory side saw. gate_at>0 freezes clk_en for GATE_LEN cycles after
    // that many cycles.
    task automatic xfer(input bit f, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata,
                        input int gate_at,
                        output int lat, output int nstb,
                        output logic [31:0] saddr, output logic [31:0] swdata,
                        output bit swr, output logic [31:0] rdata,
                        output bit xvalid);
        logic [31:0] snap_ctl;
        logic [31:0] snap_dat;
        int n;
        bit done;
        if_req  = f;
        if_addr = addr;
        d_rd    = rd;
        d_wr    = wr;
        d_addr  = addr;
        d_wdata = wdata;
        lat = -1; nstb = 0; saddr = '0; swdata = '0; swr = 1'b0;
        rdata = '0; xvalid = 1'b0; n = 0; done = 1'b0;
        while (!done && n < 60) begin
            tick();
            n++;
            if (mem_rd || mem_wr) begin
                nstb++;
                saddr  = mem_addr;
                swdata = mem_wdata;
                swr    = mem_wr;
            end
            if (f ? d_valid : if_valid) xvalid = 1'b1;
            if (f ? if_valid : d_valid) begin
                lat   = n;
                rdata = f ? if_rdata : d_rdata;
                done  = 1'b1;
            end else if (n == gate_at) begin
                snap_ctl = 32'({busy, mem_rd, mem_wr, if_valid, d_valid, mem_addr[7:0]});
                snap_dat = f ? if_rdata : d_rdata;
                clk_en = 1'b0;
                repeat (GATE_LEN) begin
                    tick();
                    n++;
                    chk("gate_ctl", 32'({busy, mem_rd, mem_wr, if_valid, d_valid, mem_addr[7:0]}), snap_ctl);
                    chk("gate_rdata", f ? if_rdata : d_rdata, snap_dat);
                end
                clk_en = 1'b1;
            end
        end
        chk("xfer_done", 32'(done), 32'd1);
        if_req = 1'b0;
        d_rd   = 1'b0;
        d_wr   = 1'b0;
        tick();
        chk("valid_one_cycle", 32'({if_valid, d_valid}), 32'd0);
    endtask

    int          lat, nstb, n, nv, last, run;
    logic [31:0] saddr, swdata, rdata, a, wd, held;
    bit          swr, xv, f, wr, exp_if;

    initial begin
        nreset = 1'b1; clk_en = 1'b1;
        if_req = 1'b0; if_addr = '0;
        d_rd = 1'b0; d_wr = 1'b0; d_addr = '0; d_wdata = '0;
        #1 nreset = 1'b0;
        tick();
        tick();
        chk("reset_ctl", 32'({busy, mem_rd, mem_wr, if_valid, d_valid, err}), 32'd0);
        chk("reset_mem_addr", mem_addr, 32'd0);
        chk("reset_mem_wdata", mem_wdata, 32'd0);
        chk("reset_if_rdata", if_rdata, 32'd0);
        chk("reset_d_rdata", d_rdata, 32'd0);
        nreset = 1'b1;
        tick();

        // Lone fetch.
        xfer(1'b1, 1'b0, 1'b0, 32'h100, 32'h0, 0, lat, nstb, saddr, swdata, swr, rdata, xv);
        chk("fetch_strobes", 32'(nstb), 32'd1);
        chk("fetch_strobe_wr", 32'(swr), 32'd0);
        chk("fetch_addr", saddr, 32'h100);
        chk("fetch_latency", 32'(lat), 32'(RD_LAT + 2));
        chk("fetch_rdata", rdata, 32'hDEAD_BEEF);
        chk("fetch_no_d_valid", 32'(xv), 32'd0);

        // Data write, then read it back.
        held = d_rdata;
        xfer(1'b0, 1'b0, 1'b1, 32'h2000, 32'h1234_5678, 0, lat, nstb, saddr, swdata, swr, rdata, xv);
        ref_put(32'h2000, 32'h1234_5678);
        chk("write_strobes", 32'(nstb), 32'd1);
        chk("write_strobe_wr", 32'(swr), 32'd1);
        chk("write_addr", saddr, 32'h2000);
        chk("write_wdata", swdata, 32'h1234_5678);
        chk("write_latency", 32'(lat), 32'd2);
        chk("write_no_if_valid", 32'(xv), 32'd0);
        chk("write_keeps_d_rdata", d_rdata, held);
        xfer(1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 0, lat, nstb, saddr, swdata, swr, rdata, xv);
        chk("readback_latency", 32'(lat), 32'(RD_LAT + 2));
        chk("readback_rdata", rdata, ref_get(32'h2000));

        // Clock enable dropped mid-WAIT delays completion by exactly GATE_LEN.
        xfer(1'b1, 1'b0, 1'b0, 32'h180, 32'h0, 3, lat, nstb, saddr, swdata, swr, rdata, xv);
        chk("gated_latency", 32'(lat), 32'(RD_LAT + 2 + GATE_LEN));
        chk("gated_rdata", rdata, ref_get(32'h180));
        chk("gated_strobes", 32'(nstb), 32'd1);

        // Random isolated transactions.
        for (int k = 0; k < 16; k++) begin
            f  = 1'($urandom_range(0, 1));
            wr = f ? 1'b0 : 1'($urandom_range(0, 1));
            a  = 32'h400 + 32'($urandom_range(0, 63)) * 32'd4;
            wd = $urandom();
            xfer(f, ~f & ~wr, wr, a, wd, 0, lat, nstb, saddr, swdata, swr, rdata, xv);
            chk("rnd_strobes", 32'(nstb), 32'd1);
            chk("rnd_addr", saddr, a);
            chk("rnd_wr", 32'(swr), 32'(wr));
            chk("rnd_latency", 32'(lat), wr ? 32'd2 : 32'(RD_LAT + 2));
            chk("rnd_other_valid", 32'(xv), 32'd0);
            if (wr) begin
                chk("rnd_wdata", swdata, wd);
                ref_put(a, wd);
            end else begin
                chk("rnd_rdata", rdata, ref_get(a));
            end
        end

        // Fetch and data read both held: fetch gets one slot after STARVE_MAX data grants.
        if_req = 1'b1; if_addr = 32'h100;
        d_rd = 1'b1; d_addr = 32'h2000;
        n = 0; nv = 0; last = 0; run = 0;
        while (nv < 10 && n < 300) begin
            tick();
            n++;
            if (if_valid || d_valid) begin
                exp_if = (run == STARVE_MAX);
                chk("starve_grant_if", 32'(if_valid), 32'(exp_if));
                chk("starve_grant_d", 32'(d_valid), 32'(!exp_if));
                if (exp_if) chk("starve_if_rdata", if_rdata, ref_get(32'h100));
                else        chk("starve_d_rdata", d_rdata, ref_get(32'h2000));
                if (nv > 0) chk("starve_gap", 32'(n - last), 32'(RD_LAT + 3));
                last = n;
                nv++;
                run = exp_if ? 0 : run + 1;
            end
        end
        chk("starve_grants", 32'(nv), 32'd10);
        if_req = 1'b0; d_rd = 1'b0;
        tick();

        // Conflicting rd+wr: performed as a write, err is sticky.
        chk("err_clear_before", 32'(err), 32'd0);
        xfer(1'b0, 1'b1, 1'b1, 32'h3000, 32'hCAFE_F00D, 0, lat, nstb, saddr, swdata, swr, rdata, xv);
        ref_put(32'h3000, 32'hCAFE_F00D);
        chk("err_is_write", 32'(swr), 32'd1);
        chk("err_wdata", swdata, 32'hCAFE_F00D);
        chk("err_latency", 32'(lat), 32'd2);
        chk("err_set", 32'(err), 32'd1);
        xfer(1'b1, 1'b0, 1'b0, 32'h3000, 32'h0, 0, lat, nstb, saddr, swdata, swr, rdata, xv);
        chk("err_after_rdata", rdata, 32'hCAFE_F00D);
        chk("err_sticky_1", 32'(err), 32'd1);
        xfer(1'b0, 1'b1, 1'b0, 32'h2000, 32'h0, 0, lat, nstb, saddr, swdata, swr, rdata, xv);
        chk("err_sticky_2", 32'(err), 32'd1);

        // Reset in the middle of a read aborts it at once.
        if_req = 1'b1; if_addr = 32'h200;
        tick(); tick(); tick();
        chk("midread_busy", 32'(busy), 32'd1);
        nreset = 1'b0;
        #1;
        chk("midread_reset_ctl", 32'({busy, mem_rd, mem_wr, if_valid, d_valid, err}), 32'd0);
        if_req = 1'b0;
        tick();
        chk("midread_no_valid", 32'({if_valid, d_valid}), 32'd0);
        nreset = 1'b1;
        tick();
        xfer(1'b1, 1'b0, 1'b0, 32'h200, 32'h0, 0, lat, nstb, saddr, swdata, swr, rdata, xv);
        chk("post_reset_latency", 32'(lat), 32'(RD_LAT + 2));
        chk("post_reset_rdata", rdata, ref_get(32'h200));
        chk("post_reset_err", 32'(err), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
